// File: rtl/pulse_swallow_ctrl.sv
// -----------------------------------------------------------------------------
// pulse_swallow_ctrl
//
// Pulse-swallow controller for a P/P+1 dual-modulus divider chain. Runs on the
// prescaler output clock and owns the program counter (N) and swallow counter
// (S). Each output period lasts N clk cycles: the first S cycles drive the
// prescaler to divide by P+1, the remaining N-S cycles divide by P, giving
// N*P + S VCO cycles per period.
//
// New (N, S) ratios arrive over a valid/ready port and are double-buffered:
// a pending pair is promoted to the active pair only at a period boundary.
//
// Handshake: a transfer occurs on a rising edge where i_cfg_valid and
// o_cfg_ready are both 1. o_cfg_ready is 1 exactly when the pending buffer is
// empty. While i_cfg_valid=1 and o_cfg_ready=0, the offer (i_cfg_n, i_cfg_s)
// must be held stable. An accepted offer with N < 2 or S > N is discarded and
// flagged on o_cfg_err for one cycle.
//
// Ports
//   i_clk        prescaler output clock, rising-edge active
//   i_rst_n      asynchronous active-low reset
//   i_cfg_valid  a new (N, S) pair is offered
//   o_cfg_ready  pending buffer empty, an offer can be accepted
//   i_cfg_n      program count N (unsigned)
//   i_cfg_s      swallow count S (unsigned)
//   o_mc         modulus control, 1 = divide by P+1, 0 = divide by P
//   o_fout       one-cycle pulse in the first cycle of each output period
//   o_cfg_err    one-cycle pulse after an illegal offer was accepted
//   o_dbg_state  current FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module pulse_swallow_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [CNT_W-1:0] i_cfg_n,
   input  logic [CNT_W-1:0] i_cfg_s,
   output logic             o_mc,
   output logic             o_fout,
   output logic             o_cfg_err,
   output logic             o_dbg_state
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] r_act_n;
   logic [CNT_W-1:0] r_act_s;
   logic [CNT_W-1:0] r_pend_n;
   logic [CNT_W-1:0] r_pend_s;
   logic             r_pend_valid;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mc;
   logic             r_fout;
   logic             r_cfg_err;

   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_act_n_nxt;
   logic [CNT_W-1:0] w_act_s_nxt;
   logic             w_pend_valid_nxt;
   logic             w_load;
   logic             w_term;
   logic             w_xfer;
   logic             w_legal;
   logic             w_accept;
   logic             w_reject;
   logic             w_mc_nxt;
   logic             w_fout_nxt;

   // ---------------------------------------------------------------------------
   // Configuration port
   // ---------------------------------------------------------------------------
   assign o_cfg_ready = !r_pend_valid;
   assign w_xfer      = i_cfg_valid && !r_pend_valid;
   assign w_legal     = (i_cfg_n >= TWO) && (i_cfg_s <= i_cfg_n);
   assign w_accept    = w_xfer && w_legal;
   assign w_reject    = w_xfer && !w_legal;

   // Active N is at least 2 whenever we are in RUN, so act_n-1 never
   // underflows and the counter tops out at 2^CNT_W-2 for the largest N.
   assign w_term = (r_cnt == (r_act_n - ONE));

   // ---------------------------------------------------------------------------
   // Next-state / next-output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_act_n_nxt = r_act_n;
      w_act_s_nxt = r_act_s;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (r_pend_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_term) begin
               w_cnt_nxt = '0;
               // Only a ratio that was already pending before this edge is
               // promoted; an offer landing on the wrap edge waits a period.
               w_load    = r_pend_valid;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_load) begin
         w_act_n_nxt = r_pend_n;
         w_act_s_nxt = r_pend_s;
      end
   end

   // Load and accept are mutually exclusive: load needs pend_valid=1, accept
   // needs pend_valid=0.
   always_comb begin
      w_pend_valid_nxt = r_pend_valid;
      if (w_load) begin
         w_pend_valid_nxt = 1'b0;
      end else if (w_accept) begin
         w_pend_valid_nxt = 1'b1;
      end
   end

   // Outputs are registered from the post-edge counter and active pair so
   // that mc/fout line up with the cycle the counter value describes.
   always_comb begin
      w_mc_nxt   = 1'b0;
      w_fout_nxt = 1'b0;
      if (w_state_nxt == S_RUN) begin
         w_mc_nxt   = (w_cnt_nxt < w_act_s_nxt);
         w_fout_nxt = (w_cnt_nxt == '0);
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_act_n      <= '0;
         r_act_s      <= '0;
         r_pend_valid <= 1'b0;
         r_mc         <= 1'b0;
         r_fout       <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_act_n      <= w_act_n_nxt;
         r_act_s      <= w_act_s_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_mc         <= w_mc_nxt;
         r_fout       <= w_fout_nxt;
         r_cfg_err    <= w_reject;
      end
   end

   // The pending data itself needs no reset: it is qualified by r_pend_valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_n <= '0;
         r_pend_s <= '0;
      end else if (w_accept) begin
         r_pend_n <= i_cfg_n;
         r_pend_s <= i_cfg_s;
      end
   end

   assign o_mc        = r_mc;
   assign o_fout      = r_fout;
   assign o_cfg_err   = r_cfg_err;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pulse_swallow_ctrl
//
// Directed bench for pulse_swallow_ctrl. Expected (mc, fout) pairs are pushed
// into exp_q as each segment of stimulus is set up and popped one per clock
// as the DUT produces them. Handshake, error and reset behaviour is checked
// with direct comparisons at the relevant points.
// -----------------------------------------------------------------------------
module tb_pulse_swallow_ctrl;

   localparam int CNT_W = 8;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_cfg_valid;
   logic             o_cfg_ready;
   logic [CNT_W-1:0] i_cfg_n;
   logic [CNT_W-1:0] i_cfg_s;
   logic             o_mc;
   logic             o_fout;
   logic             o_cfg_err;
   logic             o_dbg_state;

   int               n_tests;
   int               n_fail;
   logic [1:0]       exp_q[$];

   pulse_swallow_ctrl #(.CNT_W(CNT_W)) u_dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_cfg_valid (i_cfg_valid),
      .o_cfg_ready (o_cfg_ready),
      .i_cfg_n     (i_cfg_n),
      .i_cfg_s     (i_cfg_s),
      .o_mc        (o_mc),
      .o_fout      (o_fout),
      .o_cfg_err   (o_cfg_err),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Clock and watchdog
   // ---------------------------------------------------------------------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected period shape: phase ph of an N-cycle period has mc = (ph < S)
   // and fout = (ph == 0).
   task automatic push_pat(input int n, input int s, input int start, input int count);
      for (int k = 0; k < count; k++) begin
         int ph;
         ph = (start + k) % n;
         exp_q.push_back({(ph < s) ? 1'b1 : 1'b0, (ph == 0) ? 1'b1 : 1'b0});
      end
   endtask

   task automatic push_idle(input int count);
      for (int k = 0; k < count; k++) exp_q.push_back(2'b00);
   endtask

   task automatic drain(input int count, input string tag);
      for (int k = 0; k < count; k++) begin
         logic [1:0] e;
         tick();
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: observed empty queue expected entry", tag);
         end else begin
            e = exp_q.pop_front();
            check(tag, {30'd0, o_mc, o_fout}, {30'd0, e});
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      n_tests     = 0;
      n_fail      = 0;
      i_rst_n     = 1'b0;
      i_cfg_valid = 1'b0;
      i_cfg_n     = '0;
      i_cfg_s     = '0;

      // Reset held while clocking
      tick();
      tick();
      check("rst_mc",    o_mc,        1'b0);
      check("rst_fout",  o_fout,      1'b0);
      check("rst_err",   o_cfg_err,   1'b0);
      check("rst_ready", o_cfg_ready, 1'b1);
      check("rst_state", o_dbg_state, 1'b0);
      i_rst_n = 1'b1;
      push_idle(6);
      drain(6, "idle_quiet");
      check("idle_ready", o_cfg_ready, 1'b1);

      // Basic N=4, S=1: transfer edge gives IDLE output, next edge starts
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd4;
      i_cfg_s     = 8'd1;
      push_idle(1);
      drain(1, "basic_xfer");
      i_cfg_valid = 1'b0;
      check("basic_ready_low", o_cfg_ready, 1'b0);
      push_pat(4, 1, 0, 1);
      drain(1, "basic_first");
      check("basic_state_run", o_dbg_state, 1'b1);
      check("basic_ready_back", o_cfg_ready, 1'b1);
      push_pat(4, 1, 1, 13);
      drain(13, "basic_pat");          // ends at phase 1

      // Mid-period reconfiguration to N=5, S=2 offered at cnt=1
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd5;
      i_cfg_s     = 8'd2;
      push_pat(4, 1, 2, 1);
      drain(1, "reconf_xfer");
      i_cfg_valid = 1'b0;
      check("reconf_ready_low0", o_cfg_ready, 1'b0);
      push_pat(4, 1, 3, 1);
      drain(1, "reconf_old");
      check("reconf_ready_low1", o_cfg_ready, 1'b0);
      push_pat(5, 2, 0, 1);
      drain(1, "reconf_new0");
      check("reconf_ready_back", o_cfg_ready, 1'b1);
      push_pat(5, 2, 1, 9);
      drain(9, "reconf_pat");          // ends at phase 4

      // Illegal offers back to back: N=1,S=0 then N=4,S=5
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd1;
      i_cfg_s     = 8'd0;
      push_pat(5, 2, 0, 1);
      drain(1, "ill0_pat");
      check("ill0_err",   o_cfg_err,   1'b1);
      check("ill0_ready", o_cfg_ready, 1'b1);
      i_cfg_n     = 8'd4;
      i_cfg_s     = 8'd5;
      push_pat(5, 2, 1, 1);
      drain(1, "ill1_pat");
      check("ill1_err",   o_cfg_err,   1'b1);
      check("ill1_ready", o_cfg_ready, 1'b1);
      i_cfg_valid = 1'b0;
      push_pat(5, 2, 2, 1);
      drain(1, "ill_clear_pat");
      check("ill_err_clear", o_cfg_err, 1'b0);
      push_pat(5, 2, 3, 7);
      drain(7, "ill_unchanged");       // ends at phase 4

      // Offer N=3,S=3 on the wrap edge: must not apply until the next wrap
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd3;
      i_cfg_s     = 8'd3;
      push_pat(5, 2, 0, 1);
      drain(1, "wrap_xfer");
      i_cfg_valid = 1'b0;
      check("wrap_ready_low", o_cfg_ready, 1'b0);
      push_pat(5, 2, 1, 4);
      drain(4, "wrap_no_bypass");
      push_pat(3, 3, 0, 9);
      drain(9, "full_swallow");        // ends at phase 2
      check("full_ready", o_cfg_ready, 1'b1);

      // Reset with a pending ratio (N=4,S=0) mid-period
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd4;
      i_cfg_s     = 8'd0;
      push_pat(3, 3, 0, 1);
      drain(1, "pend_xfer");
      i_cfg_valid = 1'b0;
      check("pend_ready_low", o_cfg_ready, 1'b0);
      push_pat(3, 3, 1, 1);
      drain(1, "pend_run");
      #2;
      i_rst_n = 1'b0;
      #1;
      check("arst_mc",    o_mc,        1'b0);
      check("arst_fout",  o_fout,      1'b0);
      check("arst_ready", o_cfg_ready, 1'b1);
      check("arst_state", o_dbg_state, 1'b0);
      tick();
      tick();
      i_rst_n = 1'b1;
      push_idle(8);
      drain(8, "arst_pend_lost");
      check("arst_still_idle", o_dbg_state, 1'b0);

      // Largest N with S=0: mc never set, fout every 255 cycles, no overflow
      i_cfg_valid = 1'b1;
      i_cfg_n     = 8'd255;
      i_cfg_s     = 8'd0;
      push_idle(1);
      drain(1, "max_xfer");
      i_cfg_valid = 1'b0;
      push_pat(255, 0, 0, 257);
      drain(257, "max_n_s0");

      n_tests++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL queue_empty: observed %0d expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
